// File: rtl/subneg_mem_if.sv
// ----------------------------------------------------------------------------
// subneg_mem_if : host loader port + core req/ack port + status for the
//                 subneg memory server.
// Rev 1.0 - initial release
// ----------------------------------------------------------------------------
`default_nettype none

interface subneg_mem_if #(
  parameter int AW = 6
);
  logic          host_load_en;
  logic          host_valid;
  logic [7:0]    host_data;
  logic          host_ready;
  logic          cpu_req;
  logic          cpu_we;
  logic [AW-1:0] cpu_addr;
  logic [7:0]    cpu_wdata;
  logic          cpu_ack;
  logic [7:0]    cpu_rdata;
  logic [7:0]    display;
  logic          load_done;
  logic          err;

  modport slave (
    input  host_load_en, host_valid, host_data,
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output host_ready, cpu_ack, cpu_rdata, display, load_done, err
  );

  modport master (
    output host_load_en, host_valid, host_data,
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  host_ready, cpu_ack, cpu_rdata, display, load_done, err
  );
endinterface

`default_nettype wire

// File: rtl/subneg_mem_server.sv
// ----------------------------------------------------------------------------
// subneg_mem_server : program/data RAM for the subneg core with a byte-stream
//                     host loader and a memory-mapped display register.
// Rev 1.0 - initial release
// ----------------------------------------------------------------------------
`default_nettype none

module subneg_mem_server #(
  parameter int unsigned DEPTH     = 32,
  parameter int unsigned AW        = 6,
  parameter int unsigned DISP_ADDR = 21
) (
  input  wire logic   clk,
  input  wire logic   reset,
  subneg_mem_if.slave bus
);

  localparam int unsigned IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {
    SERVE     = 2'd0,
    LOAD_ADDR = 2'd1,
    LOAD_DATA = 2'd2,
    DONE      = 2'd3
  } state_t;

  state_t        state, state_nx;
  logic [AW-1:0] ptr, ptr_nx;
  logic          load_we;
  logic          host_addr_bad;

  logic [7:0]    mem [DEPTH];
  logic          cpu_ack, err;
  logic [7:0]    cpu_rdata, display;

  logic          cpu_acc, cpu_oor, cpu_disp, cpu_mem_we;

  // Loader FSM. Dropping host_load_en wins over a byte in the same cycle.
  always_comb begin
    state_nx      = state;
    ptr_nx        = ptr;
    load_we       = 1'b0;
    host_addr_bad = 1'b0;
    case (state)
      SERVE: begin
        if (bus.host_load_en) state_nx = LOAD_ADDR;
      end
      LOAD_ADDR: begin
        if (!bus.host_load_en) begin
          state_nx = DONE;
        end else if (bus.host_valid) begin
          state_nx = LOAD_DATA;
          if (32'(bus.host_data) >= DEPTH) begin
            host_addr_bad = 1'b1;
            ptr_nx        = '0;
          end else begin
            ptr_nx = bus.host_data[AW-1:0];
          end
        end
      end
      LOAD_DATA: begin
        if (!bus.host_load_en) begin
          state_nx = DONE;
        end else if (bus.host_valid) begin
          load_we = 1'b1;
          ptr_nx  = (ptr == AW'(DEPTH - 1)) ? '0 : ptr + AW'(1);
        end
      end
      DONE: begin
        state_nx = SERVE;
      end
      default: begin
        state_nx = SERVE;
      end
    endcase
  end

  always_comb begin
    cpu_acc    = (state == SERVE) && bus.cpu_req;
    cpu_oor    = 32'(bus.cpu_addr) >= DEPTH;
    cpu_disp   = bus.cpu_addr == AW'(DISP_ADDR);
    cpu_mem_we = cpu_acc && bus.cpu_we && !cpu_oor && !cpu_disp;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= SERVE;
      ptr       <= '0;
      cpu_ack   <= 1'b0;
      cpu_rdata <= 8'h00;
      display   <= 8'h00;
      err       <= 1'b0;
    end else begin
      state   <= state_nx;
      ptr     <= ptr_nx;
      cpu_ack <= cpu_acc;
      if (cpu_acc && !bus.cpu_we) begin
        if (cpu_oor)
          cpu_rdata <= 8'h00;
        else if (cpu_disp)
          cpu_rdata <= display;
        else
          cpu_rdata <= mem[bus.cpu_addr[IW-1:0]];
      end
      if (cpu_acc && bus.cpu_we && cpu_disp)
        display <= bus.cpu_wdata;
      if (host_addr_bad || (cpu_acc && cpu_oor))
        err <= 1'b1;
    end
  end

  // RAM has no reset so a loaded program survives it.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (load_we)
        mem[ptr[IW-1:0]] <= bus.host_data;
      else if (cpu_mem_we)
        mem[bus.cpu_addr[IW-1:0]] <= bus.cpu_wdata;
    end
  end

  assign bus.host_ready = (state == LOAD_ADDR) || (state == LOAD_DATA);
  assign bus.load_done  = (state == DONE);
  assign bus.cpu_ack    = cpu_ack;
  assign bus.cpu_rdata  = cpu_rdata;
  assign bus.display    = display;
  assign bus.err        = err;

endmodule

`default_nettype wire
